reg_file_dump_unit: RTL and testbench

//   Hardware counterpart of the bench-side register-file printout.
//   On a start pulse, walks every entry of the CPU register file through a spare async read port.

---
 rtl/cpu_dbg_pkg.sv | 23 ++
 rtl/reg_file_dump_unit.sv | 150 +++++++++++++++
 tb/tb_reg_file_dump_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-block definitions: dump FSM state encodings and the default
// register-file geometry used by the dump unit, the RF and the bench.
package cpu_dbg_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ,
        S_SEND = ST_SEND,
        S_CSUM = ST_CSUM,
        S_FIN  = ST_FIN
    } dump_state_t;

endpackage

// File: rtl/reg_file_dump_unit.sv
// Walks the CPU register file through a spare async read port and streams
// {index, data} words on valid/ready. Optional trailing XOR word: REG_DUMP_CHECKSUM_EN.
module reg_file_dump_unit
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    dump_state_t       w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [ADDR_W-1:0] r_out_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              r_last;
    logic              w_handshake;
    logic              w_is_last_idx;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    assign w_handshake   = r_valid && out_ready_i;
    assign w_is_last_idx = (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_state_next = S_READ;
            S_READ: w_state_next = S_SEND;
            S_SEND: begin
                if (w_handshake) begin
                    if (w_is_last_idx) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_state_next = S_CSUM;
`else
                        w_state_next = S_FIN;
`endif
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: if (w_handshake) w_state_next = S_FIN;
`endif
            S_FIN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_out_idx  <= '0;
            r_out_data <= '0;
            r_last     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_csum <= '0;
`endif
                    end
                end
                S_READ: begin
                    // Data is captured here; later RF writes to this entry are not seen.
                    r_out_data <= rf_data_i;
                    r_out_idx  <= r_idx;
                    r_valid    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_last     <= 1'b0;
                    r_csum     <= r_csum ^ rf_data_i;
`else
                    r_last     <= w_is_last_idx;
`endif
                end
                S_SEND: begin
                    if (w_handshake) begin
                        if (w_is_last_idx) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Checksum word follows immediately; valid stays high.
                            r_out_data <= r_csum;
                            r_out_idx  <= '0;
                            r_last     <= 1'b1;
`else
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rf_addr_o   = r_idx;
    assign out_valid_o = r_valid;
    assign out_idx_o   = r_out_idx;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_last;

endmodule

// File: tb/tb_reg_file_dump_unit.sv
// Self-checking bench for reg_file_dump_unit: directed scenarios plus randomized
// ready/RF contents, checked against a snapshot-based word-list model.
module tb_reg_file_dump_unit;
    import cpu_dbg_pkg::*;

    localparam int N  = DEF_NUM_REGS;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] rf [N];
    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    reg_file_dump_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rf_addr_o   (rf_addr),
        .rf_data_i   (rf_data),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_idx_o   (out_idx),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        bit            last;
    } word_t;

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Expected stream: every RF entry in index order as it stands at start,
    // then the XOR of all entries when the checksum word is enabled.
    task automatic build_expected();
        logic [DW-1:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            x ^= rf[i];
            exp_q.push_back('{i, rf[i], (i == N - 1) && (CSUM_EN == 0)});
        end
        if (CSUM_EN != 0) exp_q.push_back('{0, x, 1'b1});
    endtask

    task automatic do_dump(input string name, input bit rnd_ready, input int stall_idx,
                           input int stall_len, input int restart_idx, input bit mutate,
                           input int exp_done_cyc);
        int    n;
        int    words;
        int    dones;
        int    done_cyc;
        int    stall_cnt;
        bit    restarted;
        word_t w;
        build_expected();
        words = 0; dones = 0; done_cyc = -1; stall_cnt = 0; restarted = 0;
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        chk({name, ":idle_done"}, done_o, 0);
        chk({name, ":idle_busy"}, busy_o, 0);
        chk({name, ":idle_valid"}, out_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (dones == 0 && n <= 600) begin
            @(negedge clk);
            if (n == 1) chk({name, ":busy_after_start"}, busy_o, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk({name, ":extra_word"}, out_valid, 0);
                end else begin
                    w = exp_q[0];
                    chk({name, ":idx"}, out_idx, w.idx);
                    chk({name, ":data"}, out_data, w.data);
                    chk({name, ":last"}, out_last, w.last);
                    if (ready) begin
                        void'(exp_q.pop_front());
                        words++;
                    end
                end
            end
            if (done_o) begin
                dones++;
                done_cyc = n;
            end
            if (dones == 0) begin
                @(posedge clk); #1;
                if (stall_idx >= 0 && out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
                    ready = 1'b0;
                    stall_cnt++;
                end else begin
                    ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (restart_idx >= 0 && !restarted && out_valid && int'(out_idx) == restart_idx) begin
                    start     = 1'b1;
                    restarted = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (mutate && out_valid) rf[out_idx] = $urandom();
                n++;
            end
        end
        ready = 1'b1;
        start = 1'b0;
        chk({name, ":done_seen"}, dones, 1);
        chk({name, ":word_count"}, words, N + CSUM_EN);
        if (exp_done_cyc > 0) chk({name, ":done_cycle"}, done_cyc, exp_done_cyc);
        chk({name, ":busy_at_done"}, busy_o, 0);
        chk({name, ":valid_at_done"}, out_valid, 0);
        $display("dump %s: words=%0d done_cycle=%0d", name, words, done_cyc);
    endtask

    task automatic abort_dump();
        int n;
        bit found;
        found = 0;
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            if (out_valid && out_idx == AW'(7)) found = 1;
            n++;
        end
        chk("abort:reach_idx7", found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort:valid", out_valid, 0);
        chk("abort:busy", busy_o, 0);
        chk("abort:done", done_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort:no_done", done_o, 0);
            chk("abort:stay_idle", busy_o, 0);
        end
        $display("dump abort: reset raised at idx 7");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < N; i++) rf[i] = DW'(100 + i);
        repeat (3) @(negedge clk);
        chk("reset:busy", busy_o, 0);
        chk("reset:done", done_o, 0);
        chk("reset:valid", out_valid, 0);
        chk("reset:last", out_last, 0);
        chk("reset:idx", out_idx, 0);
        chk("reset:data", out_data, 0);
        chk("reset:addr", rf_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_dump("basic", 0, -1, 0, -1, 0, 2 * N + 1 + CSUM_EN);
        do_dump("stall_idx3", 0, 3, 5, -1, 0, 2 * N + 1 + CSUM_EN + 5);
        do_dump("restart_idx10", 0, -1, 0, 10, 0, 2 * N + 1 + CSUM_EN);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("restart:no_second_dump", out_valid | busy_o | done_o, 0);
        end

        abort_dump();
        do_dump("after_abort", 0, -1, 0, -1, 0, 2 * N + 1 + CSUM_EN);

        for (int i = 0; i < N; i++) rf[i] = '0;
        rf[1] = 32'h0000_00FF;
        rf[2] = 32'h0000_0F0F;
        do_dump("csum_pattern", 0, -1, 0, -1, 0, 2 * N + 1 + CSUM_EN);

        for (int i = 0; i < N; i++) rf[i] = $urandom();
        do_dump("b2b_first", 0, -1, 0, -1, 0, 2 * N + 1 + CSUM_EN);
        do_dump("b2b_second", 0, -1, 0, -1, 0, 2 * N + 1 + CSUM_EN);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) rf[i] = $urandom();
            do_dump("random", 1, -1, 0, int'($urandom_range(0, N - 1)), 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
